// File: rtl/second_mode_exit_controller_if.sv
// Mode/menu/tick inputs and exit-request outputs of the second-mode
// exit controller, bundled for the controller and its environment.
interface second_mode_exit_controller_if #(
    parameter int MODE_WIDTH = 3
);
    logic [MODE_WIDTH-1:0] current_mode;
    logic                  menu_signal;
    logic                  sec_tick;
    logic                  exit_toggle;
    logic                  exit_cause;
    logic [6:0]            remaining_sec;
    logic                  countdown_active;

    modport master (
        output current_mode,
        output menu_signal,
        output sec_tick,
        input  exit_toggle,
        input  exit_cause,
        input  remaining_sec,
        input  countdown_active
    );

    modport slave (
        input  current_mode,
        input  menu_signal,
        input  sec_tick,
        output exit_toggle,
        output exit_cause,
        output remaining_sec,
        output countdown_active
    );
endinterface

// File: rtl/second_mode_exit_controller.sv
// Counts down the second-mode session and requests a return to stand
// mode on timeout or on a fresh menu press.
module second_mode_exit_controller #(
    parameter int                    MODE_WIDTH  = 3,
    parameter logic [MODE_WIDTH-1:0] STAND_CODE  = 3'd1,
    parameter logic [MODE_WIDTH-1:0] SECOND_CODE = 3'd2,
    parameter int                    DURATION_S  = 60
) (
    input logic                     clk,
    input logic                     rstn,
    second_mode_exit_controller_if.slave bus
);
    localparam logic [6:0] DUR = 7'(DURATION_S);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        EXIT
    } state_t;

    state_t     state_q, state_d;
    logic       menu_d;
    logic       tog_q, tog_d;
    logic       cause_q, cause_d;
    logic       act_q, act_d;
    logic [6:0] rem_q, rem_d;

    logic in_second;
    logic leave;
    logic menu_edge;

    // Stand and any unrecognised code both end the session.
    assign in_second = (bus.current_mode == SECOND_CODE);
    assign leave     = !in_second || (bus.current_mode == STAND_CODE);
    assign menu_edge = bus.menu_signal && !menu_d;

    always_comb begin
        state_d = state_q;
        tog_d   = tog_q;
        cause_d = cause_q;
        act_d   = act_q;
        rem_d   = rem_q;
        unique case (state_q)
            IDLE: begin
                if (in_second) begin
                    state_d = RUN;
                    rem_d   = DUR;
                    act_d   = 1'b1;
                    tog_d   = 1'b0;
                    cause_d = 1'b0;
                end
            end
            RUN: begin
                if (leave) begin
                    state_d = IDLE;
                    rem_d   = '0;
                    act_d   = 1'b0;
                    tog_d   = 1'b0;
                    cause_d = 1'b0;
                end else if (menu_edge) begin
                    // Manual exit wins over a coincident final tick.
                    state_d = EXIT;
                    tog_d   = 1'b1;
                    cause_d = 1'b1;
                    act_d   = 1'b0;
                end else if (bus.sec_tick && rem_q != '0) begin
                    rem_d = rem_q - 7'd1;
                    if (rem_q == 7'd1) begin
                        state_d = EXIT;
                        tog_d   = 1'b1;
                        cause_d = 1'b0;
                        act_d   = 1'b0;
                    end
                end
            end
            EXIT: begin
                if (leave) begin
                    state_d = IDLE;
                    rem_d   = '0;
                    act_d   = 1'b0;
                    tog_d   = 1'b0;
                    cause_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                rem_d   = '0;
                act_d   = 1'b0;
                tog_d   = 1'b0;
                cause_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            menu_d  <= 1'b0;
            tog_q   <= 1'b0;
            cause_q <= 1'b0;
            act_q   <= 1'b0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            menu_d  <= bus.menu_signal;
            tog_q   <= tog_d;
            cause_q <= cause_d;
            act_q   <= act_d;
            rem_q   <= rem_d;
        end
    end

    assign bus.exit_toggle      = tog_q;
    assign bus.exit_cause       = cause_q;
    assign bus.remaining_sec    = rem_q;
    assign bus.countdown_active = act_q;
endmodule
